switch_debounce_scheduler: RTL and testbench



---
 rtl/switch_sched_pkg.sv | 23 ++
 rtl/switch_tick_gen.sv | 28 ++
 rtl/switch_debounce_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_switch_debounce_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_sched_pkg.sv
// Shared constants, widths and scan-FSM encoding for the switch debounce scheduler
// and its tick generator.
package switch_sched_pkg;

  localparam int c_DEF_NUM_SWITCHES = 4;
  localparam int c_DEF_TICK_CYCLES  = 25000;
  localparam int c_DEF_STABLE_TICKS = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  // Event Id width; a single-switch build still gets a 1-bit Id field.
  function automatic int id_width(input int num_switches);
    return (num_switches > 1) ? $clog2(num_switches) : 1;
  endfunction

  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks > 1) ? $clog2(stable_ticks) : 1;
  endfunction

endpackage

// File: rtl/switch_tick_gen.sv
// Free-running prescaler: counts 0..c_TICK_CYCLES-1 and raises o_Tick for the
// single cycle in which it wraps.
module switch_tick_gen #(
  parameter int c_TICK_CYCLES = 25000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  output logic o_Tick
);

  localparam int              c_CNT_W = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_TICK_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else if (r_count == c_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_Tick = (r_count == c_LAST);

endmodule

// File: rtl/switch_debounce_scheduler.sv
// N-switch debouncer with one shared prescaler, a time-multiplexed scan engine and a
// round-robin valid/ready event port. Define SWITCH_SCHED_OVERRUN_EN for o_Overrun.
module switch_debounce_scheduler
  import switch_sched_pkg::*;
#(
  parameter int  c_NUM_SWITCHES = c_DEF_NUM_SWITCHES,
  parameter int  c_TICK_CYCLES  = c_DEF_TICK_CYCLES,
  parameter int  c_STABLE_TICKS = c_DEF_STABLE_TICKS,
  localparam int c_ID_W         = id_width(c_NUM_SWITCHES)
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [c_NUM_SWITCHES-1:0] i_Switch,
  output logic [c_NUM_SWITCHES-1:0] o_Switch,
  output logic                      o_Event_Valid,
  input  logic                      i_Event_Ready,
  output logic [c_ID_W-1:0]         o_Event_Id,
  output logic                      o_Event_Press
`ifdef SWITCH_SCHED_OVERRUN_EN
  ,
  output logic                      o_Overrun,
  input  logic                      i_Overrun_Clr
`endif
);

  localparam int                 c_CNT_W    = cnt_width(c_STABLE_TICKS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_STABLE_TICKS - 1);
  localparam logic [c_ID_W-1:0]  c_IDX_LAST = c_ID_W'(c_NUM_SWITCHES - 1);

  logic [c_NUM_SWITCHES-1:0] r_sync1, r_sync2;
  logic [c_NUM_SWITCHES-1:0] r_stable, r_pending, r_dir;
  logic [c_CNT_W-1:0]        r_cnt [c_NUM_SWITCHES];
  scan_state_t               r_state, w_next_state;
  logic [c_ID_W-1:0]         r_idx, w_next_idx;
  logic [c_ID_W-1:0]         r_ptr, r_id;
  logic                      r_valid, r_press;

  logic                      w_tick, w_scan_en, w_differs, w_commit;
  logic                      w_load, w_grant_vld, w_grant;
  logic [c_ID_W-1:0]         w_grant_id;
  logic [c_NUM_SWITCHES-1:0] w_clr_mask, w_set_mask, w_pending_next;

  switch_tick_gen #(
    .c_TICK_CYCLES(c_TICK_CYCLES)
  ) u_tick_gen (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .o_Tick (w_tick)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      // NOTE: <= makes both stages sample pre-edge values; with = the two flops
      // would collapse into one and the synchroniser would lose a stage.
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing branch
    // in combinational logic would otherwise infer a latch.
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_next_state = S_SCAN;
          w_next_idx   = '0;
        end
      end
      S_SCAN: begin
        if (r_idx == c_IDX_LAST) begin
          w_next_state = S_IDLE;
          w_next_idx   = '0;
        end else begin
          w_next_idx = r_idx + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_scan_en = (r_state == S_SCAN);
  end

  assign w_differs = w_scan_en && (r_sync2[r_idx] != r_stable[r_idx]);
  assign w_commit  = w_differs && (r_cnt[r_idx] == c_CNT_LAST);

  function automatic logic [c_ID_W-1:0] wrap_id(input logic [c_ID_W-1:0] base, input int offset);
    return c_ID_W'((int'(base) + offset) % c_NUM_SWITCHES);
  endfunction

  // Round-robin search starts just after the last granted switch and wraps.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 1; k <= c_NUM_SWITCHES; k++) begin
      if (!w_grant_vld && r_pending[wrap_id(r_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = wrap_id(r_ptr, k);
      end
    end
  end

  assign w_load  = !r_valid || i_Event_Ready;
  assign w_grant = w_load && w_grant_vld;

  // A commit and a grant on the same switch in one cycle keeps the new event.
  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (w_grant)  w_clr_mask[w_grant_id] = 1'b1;
    if (w_commit) w_set_mask[r_idx]      = 1'b1;
    w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      // NOTE: the per-switch counters are a few flops rather than a RAM, so they
      // take the async reset like any other register.
      r_cnt     <= '{default: '0};
      r_stable  <= '0;
      r_dir     <= '0;
      r_pending <= '0;
    end else begin
      if (w_scan_en) begin
        if (!w_differs || w_commit) begin
          r_cnt[r_idx] <= '0;
        end else begin
          r_cnt[r_idx] <= r_cnt[r_idx] + 1'b1;
        end
      end
      if (w_commit) begin
        r_stable[r_idx] <= r_sync2[r_idx];
        r_dir[r_idx]    <= r_sync2[r_idx];
      end
      r_pending <= w_pending_next;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_press <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_grant_vld) begin
        r_valid <= 1'b1;
        r_id    <= w_grant_id;
        r_press <= r_dir[w_grant_id];
        r_ptr   <= w_grant_id;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SWITCH_SCHED_OVERRUN_EN
  logic r_overrun;
  logic w_overwrite;

  assign w_overwrite = w_commit && r_pending[r_idx] && !(w_grant && (w_grant_id == r_idx));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_overrun <= 1'b0;
    end else if (w_overwrite) begin
      r_overrun <= 1'b1;
    end else if (i_Overrun_Clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_Overrun = r_overrun;
`endif

  assign o_Switch      = r_stable;
  assign o_Event_Valid = r_valid;
  assign o_Event_Id    = r_id;
  assign o_Event_Press = r_press;

endmodule

// File: tb/tb_switch_debounce_scheduler.sv
// Directed bench for switch_debounce_scheduler (N=4, 8-cycle tick, 3 stable ticks);
// expected events are queued as stimulus is applied and popped as the DUT emits them.
module tb_switch_debounce_scheduler;

  localparam int c_N      = 4;
  localparam int c_TICK   = 8;
  localparam int c_STABLE = 3;

  typedef struct packed {
    logic [1:0] id;
    logic       press;
  } evt_t;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [c_N-1:0]  sw;
  logic [c_N-1:0]  sw_out;
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_id;
  logic            evt_press;
`ifdef SWITCH_SCHED_OVERRUN_EN
  logic            overrun;
  logic            overrun_clr;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  evt_t sb[$];

  always #5 clk = ~clk;

  switch_debounce_scheduler #(
    .c_NUM_SWITCHES(c_N),
    .c_TICK_CYCLES (c_TICK),
    .c_STABLE_TICKS(c_STABLE)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Switch     (sw),
    .o_Switch     (sw_out),
    .o_Event_Valid(evt_valid),
    .i_Event_Ready(evt_ready),
    .o_Event_Id   (evt_id),
    .o_Event_Press(evt_press)
`ifdef SWITCH_SCHED_OVERRUN_EN
    ,
    .o_Overrun    (overrun),
    .i_Overrun_Clr(overrun_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for o_Switch to reach a level, then compares it.
  task automatic wait_sw(input string tag, input logic [c_N-1:0] exp, input int budget);
    int n = 0;
    while (sw_out !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sw_out), 32'(exp));
  endtask

  // Entered at a negedge with evt_ready=1; compares the next event against the
  // scoreboard head and steps past the transfer edge.
  task automatic expect_event(input string tag, input int budget, output int waited);
    evt_t exp_e;
    waited = 0;
    while (!evt_valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " valid"}, 32'(evt_valid), 32'd1);
    if (evt_valid) begin
      if (sb.size() > 0) exp_e = sb.pop_front();
      else               exp_e = 'x;
      check({tag, " id"},    32'(evt_id),    32'(exp_e.id));
      check({tag, " press"}, 32'(evt_press), 32'(exp_e.press));
    end
    @(negedge clk);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (evt_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int w;
    int held_bad;
    int seen;

    // ---- reset with all switches held high ----
    rst_l     = 1'b0;
    sw        = 4'b1111;
    evt_ready = 1'b0;
`ifdef SWITCH_SCHED_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    repeat (5) @(negedge clk);
    check("rst o_Switch", 32'(sw_out),    32'd0);
    check("rst valid",    32'(evt_valid), 32'd0);
    check("rst id",       32'(evt_id),    32'd0);
    check("rst press",    32'(evt_press), 32'd0);
`ifdef SWITCH_SCHED_OVERRUN_EN
    check("rst overrun",  32'(overrun),   32'd0);
`endif
    rst_l = 1'b1;
    sb.push_back('{id: 2'd0, press: 1'b1});
    sb.push_back('{id: 2'd1, press: 1'b1});
    sb.push_back('{id: 2'd2, press: 1'b1});
    sb.push_back('{id: 2'd3, press: 1'b1});
    // Two ticks have been sampled after 20 cycles; commit needs the third.
    repeat (20) @(negedge clk);
    check("pwr no early commit", 32'(sw_out), 32'd0);
    wait_sw("pwr o_Switch", 4'b1111, 40);
    evt_ready = 1'b1;
    expect_event("pwr ev0", 40, w);
    expect_event("pwr ev1", 40, w);
    check("pwr ev1 b2b", 32'(w), 32'd0);
    expect_event("pwr ev2", 40, w);
    expect_event("pwr ev3", 40, w);
    check("pwr ev3 b2b", 32'(w), 32'd0);

    // ---- bounce on switch 2 from a fresh reset ----
    sw    = 4'b0000;
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    // Bounce starts on an even edge after reset release, so the once-per-tick
    // sample of switch 2 never sees three consecutive high levels.
    seen = 0;
    for (int t = 0; t < 60; t++) begin
      sw[2] = ((t / 5) % 2 == 0);
      @(negedge clk);
      if (evt_valid) seen++;
    end
    check("bounce no event", 32'(seen), 32'd0);
    check("bounce o_Switch", 32'(sw_out), 32'd0);
    sw[2] = 1'b1;
    sb.push_back('{id: 2'd2, press: 1'b1});
    expect_event("bounce settle", 60, w);
    check("bounce o_Switch2", 32'(sw_out), 32'b0100);
    quiet("bounce single event", 40);

    // ---- backpressure: switches 1 and 3 pending with ready low ----
    evt_ready = 1'b0;
    sw        = 4'b1110;
    wait_sw("bp o_Switch", 4'b1110, 60);
    held_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(evt_valid === 1'b1 && evt_id === 2'd1 && evt_press === 1'b1)) held_bad++;
    end
    check("bp held stable", 32'(held_bad), 32'd0);
    sb.push_back('{id: 2'd1, press: 1'b1});
    sb.push_back('{id: 2'd3, press: 1'b1});
    evt_ready = 1'b1;
    expect_event("bp first", 5, w);
    check("bp first immediate", 32'(w), 32'd0);
    expect_event("bp second", 5, w);
    check("bp back-to-back", 32'(w), 32'd0);

    // ---- round-robin: after granting 0, switch 1 wins over a re-pended 0 ----
    evt_ready = 1'b0;
    sw        = 4'b1101;
    wait_sw("rr commit 0 and 1", 4'b1101, 60);
    sw        = 4'b1100;
    wait_sw("rr recommit 0", 4'b1100, 60);
    check("rr held id", 32'(evt_id), 32'd0);
    sb.push_back('{id: 2'd0, press: 1'b1});
    sb.push_back('{id: 2'd1, press: 1'b0});
    sb.push_back('{id: 2'd0, press: 1'b0});
    evt_ready = 1'b1;
    expect_event("rr ev0", 5, w);
    expect_event("rr ev1", 5, w);
    expect_event("rr ev2", 5, w);

    // ---- overwrite: switch 0 press then release while output is busy ----
    evt_ready = 1'b0;
`ifdef SWITCH_SCHED_OVERRUN_EN
    check("ovr clear before", 32'(overrun), 32'd0);
`endif
    sw = 4'b0100;
    wait_sw("ovr occupy slot", 4'b0100, 60);
    sw = 4'b0101;
    wait_sw("ovr press commit", 4'b0101, 60);
    sw = 4'b0100;
    wait_sw("ovr release commit", 4'b0100, 60);
`ifdef SWITCH_SCHED_OVERRUN_EN
    @(negedge clk);
    check("ovr flagged", 32'(overrun), 32'd1);
`endif
    sb.push_back('{id: 2'd3, press: 1'b0});
    sb.push_back('{id: 2'd0, press: 1'b0});
    evt_ready = 1'b1;
    expect_event("ovr ev3", 5, w);
    expect_event("ovr ev0", 5, w);
    quiet("ovr older event lost", 30);
`ifdef SWITCH_SCHED_OVERRUN_EN
    check("ovr sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr cleared", 32'(overrun), 32'd0);
`endif

    // ---- reset asserted mid-scan with events outstanding ----
    evt_ready = 1'b0;
    sw        = 4'b0001;
    wait_sw("mid commit", 4'b0001, 60);
    check("mid valid before rst", 32'(evt_valid), 32'd1);
    rst_l = 1'b0;
    sw    = 4'b0000;
    #1;
    check("mid rst valid",    32'(evt_valid), 32'd0);
    check("mid rst o_Switch", 32'(sw_out),    32'd0);
    repeat (3) @(negedge clk);
    rst_l     = 1'b1;
    evt_ready = 1'b1;
    quiet("mid no stale event", 60);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
